// File: rtl/video_pkg.sv
// Shared types and constants for the video overlay compositor.
package video_pkg;

  localparam int PIX_W  = 24;
  localparam int CH_W   = 8;
  localparam int NUM_CH = PIX_W / CH_W;

  localparam logic [PIX_W-1:0] HILITE_COLOR = 24'hFF77AA;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_OPAQUE = 2'b01,
    MODE_BLEND  = 2'b10,
    MODE_HILITE = 2'b11
  } mode_e;

  // 50/50 blend of one channel: 9-bit sum, keep the upper 8 bits.
  function automatic logic [CH_W-1:0] blend_ch(input logic [CH_W-1:0] a,
                                              input logic [CH_W-1:0] b);
    logic [CH_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CH_W:1];
  endfunction

endpackage

// File: rtl/layer_priority_encoder.sv
// Picks the lowest-index active overlay layer as a one-hot vector.
module layer_priority_encoder #(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0] hit,
  output logic [NUM_LAYERS-1:0] onehot,
  output logic                  any_hit
);

  // Two's-complement trick isolates the least significant set bit.
  assign onehot  = hit & (~hit + NUM_LAYERS'(1));
  assign any_hit = |hit;

endmodule

// File: rtl/video_overlay_compositor.sv
// Two-stage overlay compositor: stage 1 resolves the winning layer,
// stage 2 applies the compositing mode that travels with the pixel.
module video_overlay_compositor
  import video_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         valid_in,
  input  logic                         frame_start_in,
  input  logic [1:0]                   mode_in,
  input  logic [PIX_W-1:0]             camera_pixel_in,
  input  logic [NUM_LAYERS-1:0]        layer_bits_in,
  input  logic [NUM_LAYERS-1:0]        layer_en_in,
  input  logic [NUM_LAYERS-1:0]        layer_blink_in,
  input  logic [PIX_W*NUM_LAYERS-1:0]  layer_color_in,
  output logic [PIX_W-1:0]             pixel_out,
  output logic                         valid_out,
  output logic                         frame_start_out,
  output logic [1:0]                   active_mode_out
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // ---------------------------------------------------------------
  // Frame-level control: mode latch and blink timing
  // ---------------------------------------------------------------
  logic             start_valid;
  mode_e            active_mode_reg;
  logic [CNT_W-1:0] blink_cnt_reg;
  logic             blink_phase_reg;
  logic             frame_phase_reg;
  mode_e            mode_eff;
  logic             phase_eff;

  assign start_valid = valid_in & frame_start_in;

  // The frame-start pixel already uses the settings of its own frame, so
  // bypass the registers on that cycle. The blink phase of a frame is the
  // toggle state captured before that frame start's counter step, which
  // gives BLINK_FRAMES visible frames followed by BLINK_FRAMES hidden ones.
  assign mode_eff  = start_valid ? mode_e'(mode_in) : active_mode_reg;
  assign phase_eff = start_valid ? blink_phase_reg  : frame_phase_reg;

  // Latch mode and step the blink counter on each qualified frame start.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      active_mode_reg <= MODE_PASS;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      frame_phase_reg <= 1'b0;
    end else if (start_valid) begin
      active_mode_reg <= mode_e'(mode_in);
      frame_phase_reg <= blink_phase_reg;
      if (blink_cnt_reg == CNT_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign active_mode_out = active_mode_reg;

  // ---------------------------------------------------------------
  // Stage 1: layer hit resolution
  // ---------------------------------------------------------------
  logic [NUM_LAYERS-1:0] hit;
  logic [NUM_LAYERS-1:0] win_onehot;
  logic                  any_hit;
  logic [PIX_W-1:0]      masked_color [NUM_LAYERS];
  logic [PIX_W-1:0]      winner_color;

  assign hit = layer_bits_in & layer_en_in &
               ~(layer_blink_in & {NUM_LAYERS{phase_eff}});

  layer_priority_encoder #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_prio (
    .hit     (hit),
    .onehot  (win_onehot),
    .any_hit (any_hit)
  );

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_color_mask
    assign masked_color[gi] = win_onehot[gi] ? layer_color_in[gi*PIX_W +: PIX_W]
                                             : '0;
  end

  // One-hot select reduces to an OR of the masked colours.
  always_comb begin
    winner_color = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      winner_color = winner_color | masked_color[i];
    end
  end

  logic             s1_valid_reg;
  logic             s1_start_reg;
  mode_e            s1_mode_reg;
  logic [PIX_W-1:0] s1_camera_reg;
  logic [PIX_W-1:0] s1_color_reg;
  logic             s1_any_hit_reg;

  // Stage-1 pipeline register: pixel, winner and the mode it must use.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid_reg   <= 1'b0;
      s1_start_reg   <= 1'b0;
      s1_mode_reg    <= MODE_PASS;
      s1_camera_reg  <= '0;
      s1_color_reg   <= '0;
      s1_any_hit_reg <= 1'b0;
    end else begin
      s1_valid_reg   <= valid_in;
      s1_start_reg   <= start_valid;
      s1_mode_reg    <= mode_eff;
      s1_camera_reg  <= camera_pixel_in;
      s1_color_reg   <= winner_color;
      s1_any_hit_reg <= any_hit;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: compositing
  // ---------------------------------------------------------------
  logic [PIX_W-1:0] blend_pix;
  logic [PIX_W-1:0] dim_pix;
  logic [PIX_W-1:0] pixel_next;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_channel
    assign blend_pix[gi*CH_W +: CH_W] = blend_ch(s1_camera_reg[gi*CH_W +: CH_W],
                                                 s1_color_reg[gi*CH_W +: CH_W]);
    assign dim_pix[gi*CH_W +: CH_W]   = {1'b0, s1_camera_reg[gi*CH_W+1 +: CH_W-1]};
  end

  // Choose the output pixel from the mode that travelled with this pixel.
  always_comb begin
    pixel_next = s1_camera_reg;
    case (s1_mode_reg)
      MODE_PASS:   pixel_next = s1_camera_reg;
      MODE_OPAQUE: pixel_next = s1_any_hit_reg ? s1_color_reg : s1_camera_reg;
      MODE_BLEND:  pixel_next = s1_any_hit_reg ? blend_pix    : s1_camera_reg;
      MODE_HILITE: pixel_next = s1_any_hit_reg ? HILITE_COLOR : dim_pix;
      default:     pixel_next = s1_camera_reg;
    endcase
  end

  // Output register with aligned qualifiers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_out       <= '0;
      valid_out       <= 1'b0;
      frame_start_out <= 1'b0;
    end else begin
      pixel_out       <= pixel_next;
      valid_out       <= s1_valid_reg;
      frame_start_out <= s1_start_reg;
    end
  end

endmodule

// File: tb/tb_video_overlay_compositor.sv
// Scoreboard bench for video_overlay_compositor (NUM_LAYERS=4, BLINK_FRAMES=2).
module tb_video_overlay_compositor;

  logic         clk_in;
  logic         rst_in;
  logic         valid_in;
  logic         frame_start_in;
  logic [1:0]   mode_in;
  logic [23:0]  camera_pixel_in;
  logic [3:0]   layer_bits_in;
  logic [3:0]   layer_en_in;
  logic [3:0]   layer_blink_in;
  logic [95:0]  layer_color_in;
  logic [23:0]  pixel_out;
  logic         valid_out;
  logic         frame_start_out;
  logic [1:0]   active_mode_out;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic        v;
    logic        fs;
    logic [23:0] pix;
  } exp_t;

  typedef struct packed {
    logic        v;
    logic        fs;
    logic [1:0]  m;
    logic [23:0] cam;
    logic [3:0]  bits;
    logic [3:0]  en;
    logic [3:0]  blk;
    logic [23:0] pix;
  } row_t;

  exp_t sb[$];

  video_overlay_compositor #(
    .NUM_LAYERS   (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .valid_in        (valid_in),
    .frame_start_in  (frame_start_in),
    .mode_in         (mode_in),
    .camera_pixel_in (camera_pixel_in),
    .layer_bits_in   (layer_bits_in),
    .layer_en_in     (layer_en_in),
    .layer_blink_in  (layer_blink_in),
    .layer_color_in  (layer_color_in),
    .pixel_out       (pixel_out),
    .valid_out       (valid_out),
    .frame_start_out (frame_start_out),
    .active_mode_out (active_mode_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  // Apply one input row and record what must appear two cycles later.
  task automatic drive(input row_t r);
    exp_t e;
    valid_in        = r.v;
    frame_start_in  = r.fs;
    mode_in         = r.m;
    camera_pixel_in = r.cam;
    layer_bits_in   = r.bits;
    layer_en_in     = r.en;
    layer_blink_in  = r.blk;
    e.v   = r.v;
    e.fs  = r.v & r.fs;
    e.pix = r.pix;
    sb.push_back(e);
  endtask

  task automatic set_idle();
    valid_in        = 1'b0;
    frame_start_in  = 1'b0;
    mode_in         = 2'b00;
    camera_pixel_in = 24'h0;
    layer_bits_in   = 4'h0;
    layer_en_in     = 4'h0;
    layer_blink_in  = 4'h0;
  endtask

  // After release the pipeline holds two cleared (invalid) slots.
  task automatic reset_dut();
    exp_t e;
    rst_in = 1'b1;
    set_idle();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    sb.delete();
    e = '0;
    sb.push_back(e);
    sb.push_back(e);
  endtask

  // Reference compositor for randomised traffic (no blinking layers).
  function automatic logic [23:0] model_pix(input logic [1:0] mode, input logic [23:0] cam,
                                            input logic [3:0] hit);
    logic [23:0] col;
    logic [23:0] res;
    logic [8:0]  s;
    logic        any;
    col = 24'h0;
    any = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) begin
        col = layer_color_in[i*24 +: 24];
        any = 1'b1;
      end
    end
    res = cam;
    case (mode)
      2'b01: if (any) res = col;
      2'b10: if (any) begin
        for (int c = 0; c < 3; c++) begin
          s = {1'b0, cam[c*8 +: 8]} + {1'b0, col[c*8 +: 8]};
          res[c*8 +: 8] = s[8:1];
        end
      end
      2'b11: res = any ? 24'hFF77AA : {1'b0, cam[23:17], 1'b0, cam[15:9], 1'b0, cam[7:1]};
      default: res = cam;
    endcase
    return res;
  endfunction

  task automatic test_reset();
    rst_in = 1'b1;
    set_idle();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if (pixel_out !== 24'h0) $display("FAIL reset_pixel: got %06h, want 000000", pixel_out);
    else passed++;
    total++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b, want 0", valid_out);
    else passed++;
    total++;
    if (frame_start_out !== 1'b0) $display("FAIL reset_fs: got %b, want 0", frame_start_out);
    else passed++;
    total++;
    if (active_mode_out !== 2'b00) $display("FAIL reset_mode: got %b, want 00", active_mode_out);
    else passed++;
    $display("reset: outputs cleared");
  endtask

  task automatic test_opaque();
    row_t rows[4];
    row_t idle;
    exp_t e;
    idle = '0;
    reset_dut();
    layer_color_in = {24'h123456, 24'h0000FF, 24'hFF0000, 24'h00FF00};
    rows[0] = '{1'b1, 1'b1, 2'b01, 24'h111111, 4'b0101, 4'b1111, 4'b0000, 24'h00FF00};
    rows[1] = '{1'b1, 1'b0, 2'b00, 24'h222222, 4'b0100, 4'b1111, 4'b0000, 24'h0000FF};
    rows[2] = '{1'b1, 1'b0, 2'b01, 24'h333333, 4'b0000, 4'b1111, 4'b0000, 24'h333333};
    rows[3] = '{1'b1, 1'b0, 2'b01, 24'h444444, 4'b1010, 4'b1000, 4'b0000, 24'h123456};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (sb.size() == 2) begin
        e = sb.pop_front();
        total++;
        if (valid_out !== e.v || frame_start_out !== e.fs || (e.v && pixel_out !== e.pix))
          $display("FAIL opaque[%0d]: got v=%b fs=%b pix=%06h, want v=%b fs=%b pix=%06h",
                   i, valid_out, frame_start_out, pixel_out, e.v, e.fs, e.pix);
        else passed++;
        $display("opaque[%0d]: v=%b fs=%b pix=%06h", i, valid_out, frame_start_out, pixel_out);
      end
      drive(i < 4 ? rows[i] : idle);
    end
    total++;
    if (active_mode_out !== 2'b01) $display("FAIL opaque_mode: got %b, want 01", active_mode_out);
    else passed++;
  endtask

  task automatic test_blend();
    row_t rows[3];
    row_t idle;
    exp_t e;
    idle = '0;
    reset_dut();
    layer_color_in = {24'h000000, 24'h000000, 24'hFFFFFF, 24'h01FF03};
    rows[0] = '{1'b1, 1'b1, 2'b10, 24'hFF0001, 4'b0001, 4'b0001, 4'b0000, 24'h807F02};
    rows[1] = '{1'b1, 1'b0, 2'b10, 24'hFFFFFF, 4'b0010, 4'b0010, 4'b0000, 24'hFFFFFF};
    rows[2] = '{1'b1, 1'b0, 2'b10, 24'h102030, 4'b0011, 4'b0000, 4'b0000, 24'h102030};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      if (sb.size() == 2) begin
        e = sb.pop_front();
        total++;
        if (valid_out !== e.v || frame_start_out !== e.fs || (e.v && pixel_out !== e.pix))
          $display("FAIL blend[%0d]: got v=%b fs=%b pix=%06h, want v=%b fs=%b pix=%06h",
                   i, valid_out, frame_start_out, pixel_out, e.v, e.fs, e.pix);
        else passed++;
        $display("blend[%0d]: v=%b fs=%b pix=%06h", i, valid_out, frame_start_out, pixel_out);
      end
      drive(i < 3 ? rows[i] : idle);
    end
  endtask

  task automatic test_mode_latch();
    row_t rows[5];
    row_t idle;
    exp_t e;
    idle = '0;
    reset_dut();
    layer_color_in = {24'h000000, 24'h000000, 24'h000000, 24'hABCDEF};
    rows[0] = '{1'b1, 1'b1, 2'b00, 24'hA0A0A0, 4'b0001, 4'b0001, 4'b0000, 24'hA0A0A0};
    rows[1] = '{1'b1, 1'b0, 2'b11, 24'hB0B0B0, 4'b0001, 4'b0001, 4'b0000, 24'hB0B0B0};
    rows[2] = '{1'b1, 1'b0, 2'b11, 24'hC0C0C0, 4'b0000, 4'b0001, 4'b0000, 24'hC0C0C0};
    rows[3] = '{1'b1, 1'b1, 2'b11, 24'h402010, 4'b0000, 4'b0001, 4'b0000, 24'h201008};
    rows[4] = '{1'b1, 1'b0, 2'b00, 24'h555555, 4'b0001, 4'b0001, 4'b0000, 24'hFF77AA};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      if (i == 3) begin
        total++;
        if (active_mode_out !== 2'b00)
          $display("FAIL latch_mode_before: got %b, want 00", active_mode_out);
        else passed++;
      end
      if (i == 4) begin
        total++;
        if (active_mode_out !== 2'b11)
          $display("FAIL latch_mode_after: got %b, want 11", active_mode_out);
        else passed++;
      end
      if (sb.size() == 2) begin
        e = sb.pop_front();
        total++;
        if (valid_out !== e.v || frame_start_out !== e.fs || (e.v && pixel_out !== e.pix))
          $display("FAIL latch[%0d]: got v=%b fs=%b pix=%06h, want v=%b fs=%b pix=%06h",
                   i, valid_out, frame_start_out, pixel_out, e.v, e.fs, e.pix);
        else passed++;
        $display("latch[%0d]: v=%b fs=%b pix=%06h", i, valid_out, frame_start_out, pixel_out);
      end
      drive(i < 5 ? rows[i] : idle);
    end
  endtask

  // Layer 1 blinks over layer 3 (which never blinks): visible frames 0-1, 4-5.
  task automatic test_blink();
    row_t r;
    exp_t e;
    int   f;
    int   p;
    reset_dut();
    layer_color_in = {24'h333333, 24'h000000, 24'hC0FFEE, 24'h000000};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (sb.size() == 2) begin
        e = sb.pop_front();
        total++;
        if (valid_out !== e.v || frame_start_out !== e.fs || (e.v && pixel_out !== e.pix))
          $display("FAIL blink[%0d]: got v=%b fs=%b pix=%06h, want v=%b fs=%b pix=%06h",
                   i, valid_out, frame_start_out, pixel_out, e.v, e.fs, e.pix);
        else passed++;
        $display("blink[%0d]: v=%b fs=%b pix=%06h", i, valid_out, frame_start_out, pixel_out);
      end
      f = i / 3;
      p = i % 3;
      r = '0;
      if (i < 18) begin
        r.v    = 1'b1;
        r.fs   = (p == 0);
        r.m    = 2'b01;
        r.cam  = 24'h101010;
        r.bits = 4'b1010;
        r.en   = 4'b1010;
        r.blk  = 4'b0010;
        r.pix  = (((f / 2) % 2) == 0) ? 24'hC0FFEE : 24'h333333;
      end
      drive(r);
    end
  endtask

  task automatic test_valid_gaps();
    row_t rows[6];
    row_t idle;
    exp_t e;
    idle = '0;
    reset_dut();
    layer_color_in = {24'h000000, 24'h000000, 24'h000000, 24'h0A0B0C};
    rows[0] = '{1'b1, 1'b1, 2'b01, 24'h010101, 4'b0001, 4'b0001, 4'b0000, 24'h0A0B0C};
    rows[1] = '{1'b0, 1'b1, 2'b11, 24'h999999, 4'b0001, 4'b0001, 4'b0000, 24'h000000};
    rows[2] = '{1'b1, 1'b0, 2'b11, 24'h020202, 4'b0001, 4'b0001, 4'b0000, 24'h0A0B0C};
    rows[3] = '{1'b1, 1'b0, 2'b11, 24'h030303, 4'b0000, 4'b0001, 4'b0000, 24'h030303};
    rows[4] = '{1'b1, 1'b1, 2'b01, 24'h040404, 4'b0001, 4'b0001, 4'b0001, 24'h0A0B0C};
    rows[5] = '{1'b1, 1'b0, 2'b01, 24'h050505, 4'b0001, 4'b0001, 4'b0001, 24'h0A0B0C};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      if (i == 3) begin
        total++;
        if (active_mode_out !== 2'b01)
          $display("FAIL gaps_mode: got %b, want 01", active_mode_out);
        else passed++;
      end
      if (sb.size() == 2) begin
        e = sb.pop_front();
        total++;
        if (valid_out !== e.v || frame_start_out !== e.fs || (e.v && pixel_out !== e.pix))
          $display("FAIL gaps[%0d]: got v=%b fs=%b pix=%06h, want v=%b fs=%b pix=%06h",
                   i, valid_out, frame_start_out, pixel_out, e.v, e.fs, e.pix);
        else passed++;
        $display("gaps[%0d]: v=%b fs=%b pix=%06h", i, valid_out, frame_start_out, pixel_out);
      end
      drive(i < 6 ? rows[i] : idle);
    end
  endtask

  task automatic test_async_reset();
    row_t pre;
    row_t rows[2];
    row_t idle;
    exp_t e;
    idle = '0;
    reset_dut();
    layer_color_in = {24'h000000, 24'h000000, 24'h000000, 24'h00AA00};
    pre = '{1'b1, 1'b1, 2'b11, 24'h808080, 4'b0001, 4'b0001, 4'b0000, 24'hFF77AA};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (sb.size() == 2) begin
        e = sb.pop_front();
        total++;
        if (valid_out !== e.v || frame_start_out !== e.fs || (e.v && pixel_out !== e.pix))
          $display("FAIL pre_reset[%0d]: got v=%b fs=%b pix=%06h, want v=%b fs=%b pix=%06h",
                   i, valid_out, frame_start_out, pixel_out, e.v, e.fs, e.pix);
        else passed++;
        $display("pre_reset[%0d]: v=%b fs=%b pix=%06h", i, valid_out, frame_start_out, pixel_out);
      end
      drive(pre);
      pre.fs = 1'b0;
    end
    #2;
    rst_in = 1'b1;
    set_idle();
    #1;
    total++;
    if (valid_out !== 1'b0 || pixel_out !== 24'h0 || frame_start_out !== 1'b0)
      $display("FAIL async_clear: got v=%b fs=%b pix=%06h, want v=0 fs=0 pix=000000",
               valid_out, frame_start_out, pixel_out);
    else passed++;
    total++;
    if (active_mode_out !== 2'b00)
      $display("FAIL async_mode: got %b, want 00", active_mode_out);
    else passed++;
    $display("async_reset: v=%b pix=%06h mode=%b", valid_out, pixel_out, active_mode_out);
    @(negedge clk_in);
    rst_in = 1'b0;
    sb.delete();
    e = '0;
    sb.push_back(e);
    sb.push_back(e);
    rows[0] = '{1'b1, 1'b0, 2'b11, 24'h446688, 4'b0001, 4'b0001, 4'b0000, 24'h446688};
    rows[1] = '{1'b1, 1'b0, 2'b11, 24'h123456, 4'b0001, 4'b0001, 4'b0000, 24'h123456};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (sb.size() == 2) begin
        e = sb.pop_front();
        total++;
        if (valid_out !== e.v || frame_start_out !== e.fs || (e.v && pixel_out !== e.pix))
          $display("FAIL post_reset[%0d]: got v=%b fs=%b pix=%06h, want v=%b fs=%b pix=%06h",
                   i, valid_out, frame_start_out, pixel_out, e.v, e.fs, e.pix);
        else passed++;
        $display("post_reset[%0d]: v=%b fs=%b pix=%06h", i, valid_out, frame_start_out, pixel_out);
      end
      drive(i < 2 ? rows[i] : idle);
    end
  endtask

  task automatic test_random();
    row_t r;
    exp_t e;
    logic [1:0] amode;
    int p;
    reset_dut();
    layer_color_in = {$urandom, $urandom, $urandom};
    amode = 2'b00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (sb.size() == 2) begin
        e = sb.pop_front();
        total++;
        if (valid_out !== e.v || frame_start_out !== e.fs || (e.v && pixel_out !== e.pix))
          $display("FAIL random[%0d]: got v=%b fs=%b pix=%06h, want v=%b fs=%b pix=%06h",
                   i, valid_out, frame_start_out, pixel_out, e.v, e.fs, e.pix);
        else passed++;
        $display("random[%0d]: v=%b fs=%b pix=%06h", i, valid_out, frame_start_out, pixel_out);
      end
      r = '0;
      if (i < 48) begin
        p      = i % 12;
        r.v    = (p == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        r.fs   = (p == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
        r.m    = 2'($urandom_range(0, 3));
        r.cam  = 24'($urandom);
        r.bits = 4'($urandom);
        r.en   = 4'($urandom);
        r.blk  = 4'b0000;
        if (r.v && r.fs) amode = r.m;
        r.pix  = model_pix(amode, r.cam, r.bits & r.en);
      end
      drive(r);
    end
  endtask

  initial begin
    rst_in         = 1'b1;
    layer_color_in = 96'h0;
    set_idle();
    test_reset();
    test_opaque();
    test_blend();
    test_mode_latch();
    test_blink();
    test_valid_gaps();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
